// File: rtl/imem_pkg.sv
// Shared constants and types for the IF-stage instruction memory.
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] addr;
        logic        fault;
    } imem_rsp_t;

endpackage

// File: rtl/imem_fetch_if.sv
// Fetch request/response bundle between the PC logic and the instruction memory.
// A request transfers on a rising edge where req_valid && req_ready; req_ready never depends on req_valid.
interface imem_fetch_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [31:0]     rsp_instr;
    logic [XLEN-1:0] rsp_addr;
    logic            rsp_fault;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
    );
endinterface

// File: rtl/imem_bank.sv
// DEPTH x 32 word array: one synchronous write port, one synchronous read port.
// A read and write to the same index on one edge returns the new word.
module imem_bank
    import imem_pkg::*;
#(
    parameter int    DEPTH     = 64,
    parameter string INIT_FILE = ""
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [idx_w(DEPTH)-1:0] waddr,
    input  logic [31:0]             wdata,
    input  logic                    re,
    input  logic [idx_w(DEPTH)-1:0] raddr,
    output logic [31:0]             rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata is left untouched when re is low so a stalled response keeps its word.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/imem_fetch.sv
// IF-stage instruction memory: 1-cycle fetch with stall hold, flush-to-NOP,
// misalignment/range fault reporting and a run-time word write port.
module imem_fetch
    import imem_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          DEPTH     = 64,
    parameter string       INIT_FILE = "",
    parameter logic [31:0] NOP_INSTR = imem_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_fetch_if.slave        fetch,
    input  logic               stall,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [XLEN-1:0]    wr_addr,
    input  logic [31:0]        wr_data
);
    localparam int IW = idx_w(DEPTH);

    logic            req_fault;
    logic            wr_legal;
    logic            accept;
    logic            valid_q;
    logic            fault_q;
    logic [XLEN-1:0] addr_q;
    logic [31:0]     bank_rdata;
    imem_rsp_t       rsp;

    // Range checks use the whole word address so indices >= DEPTH fault rather than alias.
    assign req_fault = (fetch.req_addr[1:0] != 2'b00) ||
                       (fetch.req_addr[XLEN-1:2] >= (XLEN-2)'(DEPTH));
    assign wr_legal  = (wr_addr[1:0] == 2'b00) &&
                       (wr_addr[XLEN-1:2] < (XLEN-2)'(DEPTH));

    assign fetch.req_ready = !stall;
    assign accept          = fetch.req_valid && !stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            addr_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (stall) begin
            valid_q <= valid_q;
        end else if (fetch.req_valid) begin
            valid_q <= 1'b1;
            fault_q <= req_fault;
            addr_q  <= fetch.req_addr;
        end else begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end
    end

    imem_bank #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_bank (
        .clk   (clk),
        .we    (wr_en && wr_legal),
        .waddr (wr_addr[IW+1:2]),
        .wdata (wr_data),
        .re    (accept && !req_fault),
        .raddr (fetch.req_addr[IW+1:2]),
        .rdata (bank_rdata)
    );

    // The bank word is only meaningful behind a valid, non-faulting response.
    always_comb begin
        rsp       = '0;
        rsp.valid = valid_q;
        rsp.fault = fault_q;
        rsp.addr  = 32'(addr_q);
        rsp.instr = (valid_q && !fault_q) ? bank_rdata : NOP_INSTR;
    end

    assign fetch.rsp_valid = rsp.valid;
    assign fetch.rsp_instr = rsp.instr;
    assign fetch.rsp_addr  = XLEN'(rsp.addr);
    assign fetch.rsp_fault = rsp.fault;

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: directed vector table, reset-mid-fetch sequence and random traffic vs a reference model.
module tb_imem_fetch;
  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;
  logic stall, flush, wr_en;
  logic [31:0] wr_addr, wr_data;

  imem_fetch_if #(.XLEN(32)) bus ();

  imem_fetch #(.XLEN(32), .DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fetch   (bus),
    .stall   (stall),
    .flush   (flush),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_err = 0;

  logic [31:0] ref_mem [DEPTH];
  logic        e_valid;
  logic [31:0] e_instr;
  logic [31:0] e_addr;
  logic        e_fault;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DEPTH);
  endfunction

  task automatic model_reset();
    e_valid = 1'b0;
    e_instr = NOP;
    e_addr  = 32'h0;
    e_fault = 1'b0;
  endtask

  // Memory is written first so a same-edge read sees the new word.
  task automatic model_update(input bit rv, input logic [31:0] ra, input bit st, input bit fl,
                              input bit we, input logic [31:0] wa, input logic [31:0] wd);
    if (we && addr_ok(wa)) ref_mem[wa / 4] = wd;
    if (fl) begin
      e_valid = 1'b0; e_instr = NOP; e_fault = 1'b0;
    end else if (st) begin
      e_valid = e_valid;
    end else if (rv) begin
      e_valid = 1'b1;
      e_addr  = ra;
      if (!addr_ok(ra)) begin
        e_fault = 1'b1; e_instr = NOP;
      end else begin
        e_fault = 1'b0; e_instr = ref_mem[ra / 4];
      end
    end else begin
      e_valid = 1'b0; e_instr = NOP; e_fault = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(e_valid));
    check({tag, " rsp_instr"}, bus.rsp_instr, e_instr);
    check({tag, " rsp_fault"}, 32'(bus.rsp_fault), 32'(e_fault));
    if (e_valid) check({tag, " rsp_addr"}, bus.rsp_addr, e_addr);
  endtask

  // ---------------- driver ----------------
  // Inputs change just after a falling edge; outputs are compared on the next falling edge.
  task automatic apply(input bit rv, input logic [31:0] ra, input bit st, input bit fl,
                       input bit we, input logic [31:0] wa, input logic [31:0] wd,
                       input bit chk_model, input string tag);
    bus.req_valid = rv;
    bus.req_addr  = ra;
    stall   = st;
    flush   = fl;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    #1;
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'(!st));
    @(posedge clk);
    model_update(rv, ra, st, fl, we, wa, wd);
    @(negedge clk);
    if (chk_model) check_model(tag);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return {$urandom_range(0, DEPTH - 1), 2'b00} | 32'($urandom_range(1, 3));
      1:       return (32'($urandom_range(DEPTH, 4 * DEPTH)) << 2);
      2:       return $urandom;
      default: return 32'($urandom_range(0, DEPTH - 1)) << 2;
    endcase
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          rv;
    logic [31:0] ra;
    bit          st;
    bit          fl;
    bit          we;
    logic [31:0] wa;
    logic [31:0] wd;
    bit          ev;
    logic [31:0] ei;
    logic [31:0] ea;
    bit          chk_a;
    bit          ef;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // rv ra st fl we wa wd | ev ei ea chk_a ef
    tbl.push_back(vec_t'{1, 32'h0,   0, 0, 0, 32'h0,   32'h0,        1, 32'h0003A437, 32'h0,   1, 0});
    tbl.push_back(vec_t'{1, 32'h4,   0, 0, 0, 32'h0,   32'h0,        1, 32'h7D040413, 32'h4,   1, 0});
    tbl.push_back(vec_t'{1, 32'h8,   0, 0, 0, 32'h0,   32'h0,        1, 32'h00802023, 32'h8,   1, 0});
    tbl.push_back(vec_t'{1, 32'h6,   0, 0, 0, 32'h0,   32'h0,        1, NOP,          32'h6,   1, 1});
    tbl.push_back(vec_t'{1, 32'h100, 0, 0, 0, 32'h0,   32'h0,        1, NOP,          32'h100, 1, 1});
    tbl.push_back(vec_t'{0, 32'h0,   0, 0, 0, 32'h0,   32'h0,        0, NOP,          32'h0,   0, 0});
    tbl.push_back(vec_t'{1, 32'h4,   0, 0, 0, 32'h0,   32'h0,        1, 32'h7D040413, 32'h4,   1, 0});
    tbl.push_back(vec_t'{1, 32'h8,   1, 0, 0, 32'h0,   32'h0,        1, 32'h7D040413, 32'h4,   1, 0});
    tbl.push_back(vec_t'{1, 32'h8,   1, 0, 0, 32'h0,   32'h0,        1, 32'h7D040413, 32'h4,   1, 0});
    tbl.push_back(vec_t'{1, 32'h8,   1, 0, 0, 32'h0,   32'h0,        1, 32'h7D040413, 32'h4,   1, 0});
    tbl.push_back(vec_t'{1, 32'h8,   0, 0, 0, 32'h0,   32'h0,        1, 32'h00802023, 32'h8,   1, 0});
    tbl.push_back(vec_t'{1, 32'h0,   0, 1, 0, 32'h0,   32'h0,        0, NOP,          32'h8,   1, 0});
    tbl.push_back(vec_t'{1, 32'h4,   0, 0, 0, 32'h0,   32'h0,        1, 32'h7D040413, 32'h4,   1, 0});
    tbl.push_back(vec_t'{1, 32'h8,   1, 1, 0, 32'h0,   32'h0,        0, NOP,          32'h4,   1, 0});
    tbl.push_back(vec_t'{1, 32'h8,   0, 0, 1, 32'h8,   32'h00400093, 1, 32'h00400093, 32'h8,   1, 0});
    tbl.push_back(vec_t'{0, 32'h0,   0, 0, 1, 32'h102, 32'hDEADBEEF, 0, NOP,          32'h0,   0, 0});
    tbl.push_back(vec_t'{1, 32'h100, 0, 0, 1, 32'h100, 32'h12345678, 1, NOP,          32'h100, 1, 1});
    tbl.push_back(vec_t'{1, 32'h0,   0, 0, 0, 32'h0,   32'h0,        1, 32'h0003A437, 32'h0,   1, 0});
    tbl.push_back(vec_t'{1, 32'h8,   0, 0, 0, 32'h0,   32'h0,        1, 32'h00400093, 32'h8,   1, 0});
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    stall = 1'b0; flush = 1'b0; wr_en = 1'b0;
    wr_addr = 32'h0; wr_data = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset rsp_instr", bus.rsp_instr, NOP);
    check("reset rsp_addr", bus.rsp_addr, 32'h0);
    check("reset rsp_fault", 32'(bus.rsp_fault), 32'h0);
    rst_n = 1'b1;

    // Program image: three known words, the rest random.
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] d;
      case (i)
        0:       d = 32'h0003A437;
        1:       d = 32'h7D040413;
        2:       d = 32'h00802023;
        default: d = $urandom;
      endcase
      apply(0, 32'h0, 0, 0, 1, 32'(i) << 2, d, 1, $sformatf("load%0d", i));
    end

    foreach (tbl[i]) begin
      apply(tbl[i].rv, tbl[i].ra, tbl[i].st, tbl[i].fl, tbl[i].we, tbl[i].wa, tbl[i].wd, 0,
            $sformatf("row%0d", i));
      check($sformatf("row%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].ev));
      check($sformatf("row%0d rsp_instr", i), bus.rsp_instr, tbl[i].ei);
      check($sformatf("row%0d rsp_fault", i), 32'(bus.rsp_fault), 32'(tbl[i].ef));
      if (tbl[i].chk_a) check($sformatf("row%0d rsp_addr", i), bus.rsp_addr, tbl[i].ea);
    end

    // Reset lands between the accepting edge and the edge that would follow it.
    bus.req_valid = 1'b1; bus.req_addr = 32'h4;
    stall = 1'b0; flush = 1'b0; wr_en = 1'b0;
    @(posedge clk);
    model_update(1, 32'h4, 0, 0, 0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("midreset rsp_instr", bus.rsp_instr, NOP);
    check("midreset rsp_addr", bus.rsp_addr, 32'h0);
    check("midreset rsp_fault", 32'(bus.rsp_fault), 32'h0);
    bus.req_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, "post-reset w0");
    check("post-reset w0 instr", bus.rsp_instr, 32'h0003A437);
    apply(1, 32'h4, 0, 0, 0, 32'h0, 32'h0, 0, "post-reset w1");
    check("post-reset w1 instr", bus.rsp_instr, 32'h7D040413);
    apply(1, 32'h8, 0, 0, 0, 32'h0, 32'h0, 0, "post-reset w2");
    check("post-reset w2 instr", bus.rsp_instr, 32'h00400093);

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      bit          rv, st, fl, we;
      logic [31:0] ra, wa, wd;
      rv = ($urandom_range(0, 9) < 8);
      st = ($urandom_range(0, 9) < 2);
      fl = ($urandom_range(0, 9) < 1);
      we = ($urandom_range(0, 9) < 3);
      ra = rand_addr();
      wa = ($urandom_range(0, 3) == 0) ? ra : rand_addr();
      wd = $urandom;
      apply(rv, ra, st, fl, we, wa, wd, 1, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
